// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and state type for the UART transmit arbiter
package uart_pkg;

  localparam int CLK_PER_HALF_CYCLE = 542;
  localparam int DEF_BIT_CLKS       = 2 * (CLK_PER_HALF_CYCLE + 1);
  localparam int DEF_HOLD_CLKS      = 1100;
  localparam int DEF_FRAME_CLKS     = 12 * DEF_BIT_CLKS;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester handshake and UART drive bundle
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
);
  localparam int IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_ready;
  logic [IDW-1:0]     grant_id;
  logic [7:0]         tx_d;
  logic               tx_rdy;
  logic               busy;

  modport slave (
    input  req_valid, req_data,
    output req_ready, grant_id, tx_d, tx_rdy, busy
  );

  modport master (
    output req_valid, req_data,
    input  req_ready, grant_id, tx_d, tx_rdy, busy
  );
endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rtl/uart_tx_arbiter_rr_pick.sv - combinational round-robin selector
module rr_pick #(
  parameter int N_REQ = 4,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDW-1:0]   last,
  output logic [N_REQ-1:0] gnt,
  output logic             any
);

  // Search starts just after the last winner so it ends up with lowest priority.
  always_comb begin
    gnt = '0;
    any = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!any && req[(int'(last) + k) % N_REQ]) begin
        gnt[(int'(last) + k) % N_REQ] = 1'b1;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin sharing of one UART transmitter with
// self-paced frames (IDLE -> HOLD with tx_rdy high -> DRAIN -> IDLE)
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int BIT_CLKS   = DEF_BIT_CLKS,
  parameter int HOLD_CLKS  = DEF_HOLD_CLKS,
  parameter int FRAME_CLKS = DEF_FRAME_CLKS
) (
  input  logic              clk_125MHz,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(N_REQ);
  localparam int CW  = $clog2(FRAME_CLKS + 1);
  localparam logic [CW-1:0] HOLD_END  = CW'(HOLD_CLKS);
  localparam logic [CW-1:0] FRAME_END = CW'(FRAME_CLKS - 1);

  if (N_REQ < 2 || N_REQ > 8 || HOLD_CLKS < BIT_CLKS || HOLD_CLKS >= 11 * BIT_CLKS ||
      FRAME_CLKS < 11 * BIT_CLKS + 1) begin : g_bad_params
    $error("uart_tx_arbiter: parameter set violates frame pacing limits");
  end

  arb_state_t     state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] grant_q, grant_d;
  logic [7:0]     txd_q, txd_d;
  logic           txrdy_q, txrdy_d;

  logic [N_REQ-1:0] gnt;
  logic             any;
  logic [IDW-1:0]   win_idx;
  logic             accept;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req  (bus.req_valid),
    .last (last_q),
    .gnt  (gnt),
    .any  (any)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt[i]) win_idx = IDW'(i);
    end
  end

  // Gated by rst_n so a reset cycle never looks like a completed handshake.
  assign accept        = (state_q == IDLE) && any && rst_n;
  assign bus.req_ready = accept ? gnt : '0;
  assign bus.grant_id  = grant_q;
  assign bus.tx_d      = txd_q;
  assign bus.tx_rdy    = txrdy_q;
  assign bus.busy      = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    grant_d = grant_q;
    txd_d   = txd_q;
    txrdy_d = txrdy_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          txd_d   = bus.req_data[{win_idx, 3'b000} +: 8];
          last_d  = win_idx;
          grant_d = win_idx;
          txrdy_d = 1'b1;
          cnt_d   = CW'(1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == HOLD_END) begin
          txrdy_d = 1'b0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == FRAME_END) state_d = IDLE;
      end
      default: state_d = DRAIN;
    endcase
  end

  // Reset lands in DRAIN so a frame the UART is still shifting can finish.
  always_ff @(posedge clk_125MHz) begin
    if (!rst_n) begin
      state_q <= DRAIN;
      cnt_q   <= '0;
      last_q  <= IDW'(N_REQ - 1);
      grant_q <= '0;
      txd_q   <= '0;
      txrdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      txd_q   <= txd_d;
      txrdy_q <= txrdy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N      = 4;
  localparam int BITC   = 8;
  localparam int HOLDC  = 10;
  localparam int FRAMEC = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #4 clk = ~clk;

  uart_tx_arbiter_if #(.N_REQ(N)) bus ();

  uart_tx_arbiter #(
    .N_REQ      (N),
    .BIT_CLKS   (BITC),
    .HOLD_CLKS  (HOLDC),
    .FRAME_CLKS (FRAMEC)
  ) dut (
    .clk_125MHz (clk),
    .rst_n      (rst_n),
    .bus        (bus)
  );

  int        n_tests = 0;
  int        n_fail  = 0;
  int        cyc     = 0;
  int        idle_at = 0;
  int        acc_at  = -1;
  int        last_m  = N - 1;
  int        grant_m = 0;
  logic [7:0] txd_m  = 8'h00;
  bit        model_ok = 1'b0;
  bit        prev_rdy = 1'b0;
  bit        auto_drop = 1'b0;
  int        acc_idx = -1;
  logic [7:0] sent_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // One clock: compare against the time-based model, then advance.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int w;
    #1;
    exp_rdy = '0;
    w = -1;
    if (model_ok) begin
      if (rst_n && cyc >= idle_at) begin
        for (int k = 1; k <= N; k++) begin
          if (w < 0 && bus.req_valid[(last_m + k) % N]) w = (last_m + k) % N;
        end
      end
      if (w >= 0) exp_rdy[w] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      chk("busy", 32'(bus.busy), 32'(cyc < idle_at));
      chk("tx_rdy", 32'(bus.tx_rdy), 32'(acc_at >= 0 && cyc > acc_at && cyc <= acc_at + HOLDC));
      chk("tx_d", 32'(bus.tx_d), 32'(txd_m));
      chk("grant_id", 32'(bus.grant_id), 32'(grant_m));
      if (bus.tx_rdy === 1'b1 && !prev_rdy) begin
        chk("frame_pending", 32'(sent_q.size() > 0), 32'd1);
        if (sent_q.size() > 0) chk("frame_byte", 32'(bus.tx_d), 32'(sent_q.pop_front()));
      end
    end
    prev_rdy = (bus.tx_rdy === 1'b1);
    acc_idx = w;
    if (w >= 0) begin
      acc_at  = cyc;
      idle_at = cyc + FRAMEC;
      last_m  = w;
      grant_m = w;
      txd_m   = bus.req_data[8*w +: 8];
      sent_q.push_back(txd_m);
    end
    @(posedge clk);
    if (!rst_n) begin
      model_ok = 1'b1;
      idle_at  = cyc + FRAMEC + 1;
      acc_at   = -1;
      last_m   = N - 1;
      grant_m  = 0;
      txd_m    = 8'h00;
    end
    cyc++;
    @(negedge clk);
    if (auto_drop && acc_idx >= 0) bus.req_valid[acc_idx] = 1'b0;
  endtask

  task automatic offer(input int i, input logic [7:0] d);
    bus.req_data[8*i +: 8] = d;
    bus.req_valid[i] = 1'b1;
  endtask

  int rst_hold;

  initial begin
    bus.req_valid = '0;
    bus.req_data  = '0;
    @(negedge clk);
    repeat (3) step();
    rst_n = 1'b1;
    repeat (FRAMEC + 5) step();

    // single byte from requester 2
    auto_drop = 1'b1;
    offer(2, 8'hA5);
    repeat (FRAMEC + 20) step();

    // all four continuously valid
    auto_drop = 1'b0;
    for (int i = 0; i < N; i++) offer(i, 8'(8'h10 + i));
    repeat (5 * FRAMEC) step();
    bus.req_valid = '0;
    repeat (FRAMEC) step();

    // fairness after skip: make 1 the last winner, then offer 1 and 3
    auto_drop = 1'b1;
    offer(1, 8'h21);
    repeat (FRAMEC + 5) step();
    auto_drop = 1'b0;
    offer(1, 8'h31);
    offer(3, 8'h33);
    repeat (3 * FRAMEC) step();
    bus.req_valid = '0;
    repeat (FRAMEC) step();

    // request raised during DRAIN must wait for IDLE
    auto_drop = 1'b1;
    offer(0, 8'h44);
    repeat (30) step();
    offer(0, 8'h45);
    repeat (2 * FRAMEC) step();

    // reset in the middle of HOLD
    offer(1, 8'h5A);
    for (int t = 0; t < 2 * FRAMEC && acc_idx < 0; t++) step();
    repeat (5) step();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    offer(2, 8'h6B);
    repeat (2 * FRAMEC + 5) step();

    // same requester held valid: one frame per slot
    auto_drop = 1'b0;
    offer(0, 8'h3C);
    repeat (4 * FRAMEC) step();
    bus.req_valid = '0;
    repeat (FRAMEC) step();

    // randomized traffic with occasional resets
    auto_drop = 1'b1;
    rst_hold = 0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 15) == 0) offer(i, 8'($urandom));
        else if (bus.req_valid[i] && $urandom_range(0, 63) == 0) bus.req_valid[i] = 1'b0;
      end
      if (rst_hold > 0) rst_hold--;
      else if ($urandom_range(0, 999) == 0) rst_hold = $urandom_range(1, 3);
      rst_n = (rst_hold == 0);
      step();
    end
    rst_n = 1'b1;
    bus.req_valid = '0;
    repeat (FRAMEC + 5) step();
    chk("frames_left", 32'(sent_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
